// File: rtl/piso_en_tx_pkg.sv
// piso_en_tx shared definitions: FSM state codes and
// a clog2 helper (min 1) for counter widths.
package piso_en_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Bits needed to count 0..v-1, never below 1.
  function automatic int clog2w(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/piso_en_tx_if.sv
// piso_en_tx bus: start/din request in, serial bit,
// bit strobe, busy and done pulse out.
interface piso_en_tx_if #(
  parameter int DBIT = 8
) ();

  logic            start;
  logic [DBIT-1:0] din;
  logic            tx_bit;
  logic            tx_en;
  logic            busy;
  logic            done_tick;

  modport master (
    output start, din,
    input  tx_bit, tx_en, busy, done_tick
  );

  modport slave (
    input  start, din,
    output tx_bit, tx_en, busy, done_tick
  );

endinterface

// File: rtl/piso_en_tx_bit_tick_gen.sv
// Mod-DVSR bit-period counter. Ports: clk, reset,
// clr_i (sync clear), en_i (count), tick_o (last count).
module piso_en_tx_bit_tick_gen
  import piso_en_tx_pkg::*;
#(
  parameter int DVSR = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = clog2w(DVSR);
  localparam logic [W-1:0] LAST = W'(DVSR - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Decoded from the registered count only.
  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_en_tx.sv
// Parallel-in serial-out transmitter, LSB first, with a
// bit-valid strobe. Ports: clk, reset, bus (slave).
module piso_en_tx
  import piso_en_tx_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int DVSR = 4
) (
  input  logic          clk,
  input  logic          reset,
  piso_en_tx_if.slave   bus
);

  localparam int NW = clog2w(DBIT);
  localparam logic [NW-1:0] NLAST = NW'(DBIT - 1);

  logic [1:0]      state_q, state_d;
  logic [DBIT-1:0] sreg_q, sreg_d;
  logic [NW-1:0]   n_q, n_d;
  logic            shifting;
  logic            tick;

  assign shifting = (state_q == ST_SHIFT);

  // Held clear outside SHIFT so each word starts at s=0.
  piso_en_tx_bit_tick_gen #(
    .DVSR (DVSR)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (!shifting),
    .en_i   (shifting),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    n_d     = n_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          sreg_d  = bus.din;
          n_d     = '0;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          sreg_d = sreg_q >> 1;
          n_d    = n_q + NW'(1);
          if (n_q == NLAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      n_q     <= n_d;
    end
  end

  assign bus.tx_bit    = shifting & sreg_q[0];
  assign bus.tx_en     = tick;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done_tick = (state_q == ST_DONE);

endmodule
